// File: rtl/pc_stack_fetch.sv
// rtl/pc_stack_fetch.sv - fetch stage: program counter, 8-level return stack, instruction register
module pc_stack_fetch #(
    parameter int              PC_W         = 11,
    parameter int              INSTR_W      = 14,
    parameter int              STACK_DEPTH  = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    Rom_addr_out,
    input  logic [INSTR_W-1:0] Rom_data_in,
    input  logic               stall_in,
    input  logic               pc_load_en,
    input  logic               call_en,
    input  logic               ret_en,
    input  logic               skip_en,
    input  logic [PC_W-1:0]    pc_load_addr,
    output logic [INSTR_W-1:0] ir_out,
    output logic [PC_W-1:0]    ir_pc_out,
    output logic               ir_valid,
    output logic [3:0]         stack_depth_out,
    output logic               stack_overflow,
    output logic               stack_underflow
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(STACK_DEPTH);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_RET,
        ACT_CALL,
        ACT_LOAD,
        ACT_SKIP,
        ACT_SEQ
    } action_t;

    // architectural state
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]    ir_pc_q;
    logic               valid_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W:0]     depth_q;
    logic               ovf_q;
    logic               unf_q;

    // return address storage; contents are meaningless until pushed
    logic [PC_W-1:0]    stack_mem [STACK_DEPTH];

    // next-state values
    action_t            act;
    logic [PC_W-1:0]    pc_d;
    logic [INSTR_W-1:0] ir_d;
    logic [PC_W-1:0]    ir_pc_d;
    logic               valid_d;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W:0]     depth_d;
    logic               ovf_d;
    logic               unf_d;
    logic               push;

    logic [PC_W-1:0]    pc_plus1;
    logic [PTR_W-1:0]   ptr_minus1;
    logic [PTR_W-1:0]   ptr_plus1;
    logic               stack_full;
    logic               stack_empty;

    assign pc_plus1    = pc_q + PC_W'(1);
    assign ptr_minus1  = ptr_q - PTR_W'(1);
    assign ptr_plus1   = ptr_q + PTR_W'(1);
    assign stack_full  = (depth_q == DEPTH_FULL);
    assign stack_empty = (depth_q == '0);

    // pick the single action for this edge; stall beats every redirect
    always_comb begin
        act = ACT_SEQ;
        if (stall_in) begin
            act = ACT_HOLD;
        end else if (ret_en) begin
            act = ACT_RET;
        end else if (call_en) begin
            act = ACT_CALL;
        end else if (pc_load_en) begin
            act = ACT_LOAD;
        end else if (skip_en) begin
            act = ACT_SKIP;
        end
    end

    // compute next PC, IR and stack bookkeeping from the chosen action
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        case (act)
            ACT_HOLD: begin
                pc_d = pc_q;
            end
            ACT_RET: begin
                // an empty stack still pops the wrapped slot, only the flag records it
                ptr_d   = ptr_minus1;
                pc_d    = stack_mem[ptr_minus1];
                ir_d    = '0;
                valid_d = 1'b0;
                ir_pc_d = pc_q;
                if (stack_empty) begin
                    unf_d = 1'b1;
                end else begin
                    depth_d = depth_q - 1'b1;
                end
            end
            ACT_CALL: begin
                // a full stack overwrites its oldest entry, depth saturates
                push    = 1'b1;
                ptr_d   = ptr_plus1;
                pc_d    = pc_load_addr;
                ir_d    = '0;
                valid_d = 1'b0;
                ir_pc_d = pc_q;
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    depth_d = depth_q + 1'b1;
                end
            end
            ACT_LOAD: begin
                pc_d    = pc_load_addr;
                ir_d    = '0;
                valid_d = 1'b0;
                ir_pc_d = pc_q;
            end
            ACT_SKIP: begin
                // the word at PC is dropped in favour of a NOP bubble
                pc_d    = pc_plus1;
                ir_d    = '0;
                valid_d = 1'b0;
                ir_pc_d = pc_q;
            end
            default: begin
                pc_d    = pc_plus1;
                ir_d    = Rom_data_in;
                valid_d = 1'b1;
                ir_pc_d = pc_q;
            end
        endcase
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            ir_pc_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // return stack write port: CALL stores the address following the call
    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            stack_mem[ptr_q] <= pc_q;
        end
    end

    assign Rom_addr_out    = pc_q;
    assign ir_out          = ir_q;
    assign ir_pc_out       = ir_pc_q;
    assign ir_valid        = valid_q;
    assign stack_depth_out = 4'(depth_q);
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: doc/pc_stack_fetch.md
Name: pc_stack_fetch

Overview:
- Fetch stage directly upstream of the program ROM. It owns the 11-bit program counter that drives the ROM address, and the 8-level hardware return stack.
- It latches the 14-bit ROM word into the instruction register for the decode/execute stage.
- It applies GOTO/CALL/RETURN/skip redirects from execute, flushing the already-fetched word with a NOP bubble.

Parameters:
- PC_W, 11, program counter / ROM address width
- INSTR_W, 14, instruction width
- STACK_DEPTH, 8, return stack entries (power of two)
- RESET_VECTOR, 11'h000, PC value after reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Rom_addr_out  output  PC_W  address to program ROM, equals PC register
- Rom_data_in  input  INSTR_W  combinational ROM word for Rom_addr_out
- stall_in  input  1  hold all state this cycle
- pc_load_en  input  1  GOTO: redirect to pc_load_addr
- call_en  input  1  CALL: push return address, redirect to pc_load_addr
- ret_en  input  1  RETURN: pop stack into PC
- skip_en  input  1  conditional skip taken: squash next instruction
- pc_load_addr  input  PC_W  branch/call target
- ir_out  output  INSTR_W  instruction register
- ir_pc_out  output  PC_W  address of instruction in ir_out
- ir_valid  output  1  ir_out is a real fetched instruction (0 = bubble)
- stack_depth_out  output  4  occupied entries, 0..8
- stack_overflow  output  1  sticky: push at depth 8
- stack_underflow  output  1  sticky: pop at depth 0

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_VECTOR; ir_out=0; ir_pc_out=0; ir_valid=0.
  - stack pointer=0; depth=0; both flags=0; stack contents are don't-care.
  - Reset mid-operation aborts any redirect immediately.
- The ROM is combinational. Fetch latency is 1 clk from PC to ir_out.
- In steady state, PC = ir_pc_out+1 while ir_valid=1 and no redirect occurred.
- Priority each rising edge, highest first: stall_in > ret_en > call_en > pc_load_en > skip_en > sequential.
- Lower-priority controls in the same cycle are ignored. Execute asserts at most one; priority is the defined fallback.
- stall_in=1: PC, IR, ir_pc, ir_valid, stack and flags hold. All controls are ignored.
- Sequential step:
  - ir_out<=Rom_data_in; ir_pc_out<=PC; ir_valid<=1.
  - PC<=PC+1 mod 2^PC_W, so 0x7FF wraps to 0x000.
- pc_load_en:
  - PC<=pc_load_addr.
  - ir_out<=0 (NOP), ir_valid<=0, ir_pc_out<=PC (the squashed address).
  - Cost is 2 cycles total for the branch.
- call_en:
  - stack[ptr]<=PC (the address after the CALL); ptr<=ptr+1 mod STACK_DEPTH.
  - PC<=pc_load_addr; flush as for pc_load_en.
  - If depth=8: stack_overflow<=1 and depth stays 8. The oldest entry is overwritten (circular); otherwise depth+1.
- ret_en:
  - ptr<=ptr-1 mod STACK_DEPTH; PC<=stack[ptr-1]; flush as for pc_load_en.
  - If depth=0: stack_underflow<=1, depth stays 0, and PC still loads the wrapped entry.
  - Otherwise depth-1.
- skip_en:
  - PC<=PC+1; ir_out<=0; ir_valid<=0; ir_pc_out<=PC.
  - The squashed instruction counts as executed as a NOP.
- Flags clear only on reset.
- A redirect arriving while ir_valid=0 (bubble) is still honoured; execute must gate it.
- Execute must not assert call/ret/load/skip for a bubble; the bench checks the fetch unit does not gate them itself.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: release rst_n with ROM[0]=0x01A5, ROM[1]=0x0103.
  - Required: Rom_addr_out=0x000 with ir_valid=0 before the first edge.
  - After edge 1: ir_out=0x01A5, ir_pc_out=0x000, Rom_addr_out=0x001.
  - After edge 2: ir_out=0x0103.
- GOTO:
  - Stimulus: when ir_pc_out=0x00C, assert pc_load_en with pc_load_addr=0x00B for 1 cycle.
  - Required next cycle: Rom_addr_out=0x00B, ir_valid=0, ir_out=0x0000.
  - Required following cycle: ir_pc_out=0x00B, ir_valid=1.
- CALL/RETURN:
  - Stimulus: CALL at ir_pc_out=0x005 with target 0x100.
  - Required: Rom_addr_out=0x100 and stack_depth_out=1.
  - Stimulus: later assert ret_en.
  - Required: Rom_addr_out=0x006, stack_depth_out=0, no flags set.
- Stack overflow and underflow:
  - Stimulus: 9 nested CALLs.
  - Required: stack_overflow=1 and depth=8.
  - Stimulus: 8 RETs.
  - Required: returns are addresses 9..2 in order, depth=0.
  - Stimulus: a 9th RET.
  - Required: stack_underflow=1.
- Skip and stall:
  - Stimulus: skip_en at ir_pc_out=0x011.
  - Required: the next ir_out is a bubble with ir_pc_out=0x012, then ir_pc_out=0x013 valid.
  - Stimulus: stall_in held 3 cycles together with pc_load_en.
  - Required: all outputs frozen and the load ignored.
- Wrap and async reset:
  - Stimulus: load PC=0x7FF.
  - Required: next Rom_addr_out=0x000.
  - Stimulus: assert rst_n=0 mid-cycle during a CALL.
  - Required: all outputs immediately return to their reset values without waiting for clk.
